// File: rtl/flops_recirc_param_pkg.sv
// rtl/flops_recirc_param_pkg.sv - shared constants, types and helpers for flops_recirc_param
package flops_recirc_param_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_RET_DEPTH = 4;
    localparam int DROP_CNT_W    = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    typedef enum logic [1:0] {
        HEAD_IDLE   = 2'd0,
        HEAD_INPUT  = 2'd1,
        HEAD_REPLAY = 2'd2
    } head_sel_e;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : drop_cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/flops_recirc_param_if.sv
// rtl/flops_recirc_param_if.sv - data/control bundle between the recirculating pipeline and its user
interface flops_recirc_param_if
    import flops_recirc_param_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RET_DEPTH = DEF_RET_DEPTH
);

    localparam int CNT_W = $clog2(RET_DEPTH + 1);

    logic             active;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_ret;
    logic [WIDTH-1:0] data_ret;
    logic [CNT_W-1:0] ret_count;
    logic             ret_full;
    logic             drop_pulse;
    drop_cnt_t        drop_count;

    modport master (
        output active, valid_in, data_in,
        input  valid_out, data_out, valid_ret, data_ret,
        input  ret_count, ret_full, drop_pulse, drop_count
    );

    modport slave (
        input  active, valid_in, data_in,
        output valid_out, data_out, valid_ret, data_ret,
        output ret_count, ret_full, drop_pulse, drop_count
    );

endinterface

// File: rtl/flops_recirc_param_fifo.sv
// rtl/flops_recirc_param_fifo.sv - return buffer holding diverted words until they can be replayed
module recirc_fifo
    import flops_recirc_param_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RET_DEPTH = DEF_RET_DEPTH
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 head,
    output logic [$clog2(RET_DEPTH+1)-1:0]   count,
    output logic                             full,
    output logic                             empty
);

    localparam int PTR_W = $clog2(RET_DEPTH);
    localparam int CNT_W = $clog2(RET_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RET_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(RET_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly log2(depth) wide, so the increment wraps for free.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/flops_recirc_param.sv
// rtl/flops_recirc_param.sv - fixed-latency pipeline whose tail either delivers or recirculates via a return buffer
module flops_recirc_param
    import flops_recirc_param_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STAGES    = DEF_STAGES,
    parameter int RET_DEPTH = DEF_RET_DEPTH
) (
    input  logic                  clk_2f,
    input  logic                  reset_L,
    flops_recirc_param_if.slave   bus
);

    localparam int CNT_W = $clog2(RET_DEPTH + 1);

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] data_q  [STAGES];
    logic [WIDTH-1:0] data_d  [STAGES];
    logic             drop_pulse_q, drop_pulse_d;
    drop_cnt_t        drop_count_q, drop_count_d;

    head_sel_e        head_sel;
    logic             tail_valid;
    logic             divert;
    logic             drop;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    recirc_fifo #(
        .WIDTH     (WIDTH),
        .RET_DEPTH (RET_DEPTH)
    ) u_fifo (
        .clk       (clk_2f),
        .resetn    (reset_L),
        .push      (divert),
        .push_data (data_q[STAGES-1]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // New input always wins over replay; push and pop never coincide since
    // diversion needs active=0 and replay needs active=1.
    always_comb begin
        head_sel = HEAD_IDLE;
        if (bus.valid_in) begin
            head_sel = HEAD_INPUT;
        end else if (bus.active && !fifo_empty) begin
            head_sel = HEAD_REPLAY;
        end
        fifo_pop = (head_sel == HEAD_REPLAY);

        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        case (head_sel)
            HEAD_INPUT: begin
                valid_d[0] = 1'b1;
                data_d[0]  = bus.data_in;
            end
            HEAD_REPLAY: begin
                valid_d[0] = 1'b1;
                data_d[0]  = fifo_head;
            end
            default: begin
                valid_d[0] = 1'b0;
                data_d[0]  = data_q[0];
            end
        endcase

        tail_valid   = valid_q[STAGES-1];
        divert       = tail_valid && !bus.active;
        drop         = divert && fifo_full;
        drop_pulse_d = drop;
        drop_count_d = drop ? sat_inc(drop_count_q) : drop_count_q;
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
            end
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.valid_out  = tail_valid && bus.active;
    assign bus.data_out   = bus.valid_out ? data_q[STAGES-1] : '0;
    assign bus.valid_ret  = !fifo_empty;
    assign bus.data_ret   = fifo_head;
    assign bus.ret_count  = fifo_count;
    assign bus.ret_full   = fifo_full;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_flops_recirc_param.sv
// tb/tb_flops_recirc_param.sv - self-checking bench for flops_recirc_param
module tb_flops_recirc_param;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic sb_en = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;

    always #5 clk = ~clk;

    flops_recirc_param_if #(.WIDTH(32), .RET_DEPTH(4)) bus ();

    flops_recirc_param #(.WIDTH(32), .STAGES(2), .RET_DEPTH(4)) dut (
        .clk_2f  (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct {
        logic        act;
        logic        vin;
        logic [31:0] din;
        logic        e_vout;
        logic [31:0] e_dout;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic [31:0] e_dret;
        logic        e_dp;
        logic [7:0]  e_dc;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic add(input logic act, input logic vin, input logic [31:0] din,
                       input logic e_vout, input logic [31:0] e_dout, input logic [2:0] e_cnt,
                       input logic e_full, input logic [31:0] e_dret, input logic e_dp,
                       input logic [7:0] e_dc);
        tbl.push_back('{act, vin, din, e_vout, e_dout, e_cnt, e_full, e_dret, e_dp, e_dc});
    endtask

    // Inputs change just after a rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic act, input logic vin, input logic [31:0] din);
        @(posedge clk);
        #1;
        bus.active   = act;
        bus.valid_in = vin;
        bus.data_in  = din;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (sb_en && bus.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(bus.valid_out), 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_data", bus.data_out, exp_w);
            end
        end
    end

    initial begin
        bus.active = 1'b1; bus.valid_in = 1'b0; bus.data_in = '0;
        drive(1, 0, 0);
        drive(1, 0, 0);
        check("rst_vout", 32'(bus.valid_out), 0);
        check("rst_dout", bus.data_out, 0);
        check("rst_vret", 32'(bus.valid_ret), 0);
        check("rst_dret", bus.data_ret, 0);
        check("rst_full", 32'(bus.ret_full), 0);
        check("rst_cnt", 32'(bus.ret_count), 0);
        check("rst_dc", 32'(bus.drop_count), 0);
        check("rst_dp", 32'(bus.drop_pulse), 0);
        reset_L = 1'b1;

        // act vin din | vout dout cnt full dret dp dc
        add(1, 1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'hA5A5_0001, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'h12, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'h13, 0, 0, 1, 0, 32'h10, 0, 0);
        add(0, 1, 32'h14, 0, 0, 2, 0, 32'h10, 0, 0);
        add(0, 0, 0, 0, 0, 3, 0, 32'h10, 0, 0);
        add(0, 0, 0, 0, 0, 4, 1, 32'h10, 0, 0);
        add(0, 0, 0, 0, 0, 4, 1, 32'h10, 1, 1);
        add(0, 0, 0, 0, 0, 4, 1, 32'h10, 0, 1);
        add(1, 0, 0, 0, 0, 4, 1, 32'h10, 0, 1);
        add(1, 0, 0, 0, 0, 3, 0, 32'h11, 0, 1);
        add(1, 0, 0, 1, 32'h10, 2, 0, 32'h12, 0, 1);
        add(1, 0, 0, 1, 32'h11, 1, 0, 32'h13, 0, 1);
        add(1, 0, 0, 1, 32'h12, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 32'h13, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].act, tbl[i].vin, tbl[i].din);
            check($sformatf("v%0d_vout", i), 32'(bus.valid_out), 32'(tbl[i].e_vout));
            check($sformatf("v%0d_dout", i), bus.data_out, tbl[i].e_dout);
            check($sformatf("v%0d_cnt", i), 32'(bus.ret_count), 32'(tbl[i].e_cnt));
            check($sformatf("v%0d_full", i), 32'(bus.ret_full), 32'(tbl[i].e_full));
            check($sformatf("v%0d_dret", i), bus.data_ret, tbl[i].e_dret);
            check($sformatf("v%0d_vret", i), 32'(bus.valid_ret), 32'(tbl[i].e_cnt != 0));
            check($sformatf("v%0d_dp", i), 32'(bus.drop_pulse), 32'(tbl[i].e_dp));
            check($sformatf("v%0d_dc", i), 32'(bus.drop_count), 32'(tbl[i].e_dc));
        end

        // New input takes priority over a pending replay.
        drive(0, 1, 32'h20);
        repeat (3) drive(0, 0, 0);
        check("prio_cnt_before", 32'(bus.ret_count), 1);
        check("prio_dret", bus.data_ret, 32'h20);
        sb_en = 1'b1;
        exp_q.push_back(32'h30);
        exp_q.push_back(32'h20);
        drive(1, 1, 32'h30);
        drive(1, 0, 0);
        check("prio_no_pop", 32'(bus.ret_count), 1);
        drive(1, 0, 0);
        check("prio_popped", 32'(bus.ret_count), 0);
        repeat (3) drive(1, 0, 0);
        check("prio_sb_drained", 32'(exp_q.size()), 0);

        // Reset with a partly filled buffer discards everything.
        drive(0, 1, 32'h40);
        drive(0, 1, 32'h41);
        drive(0, 1, 32'h42);
        repeat (3) drive(0, 0, 0);
        check("mid_cnt_before", 32'(bus.ret_count), 3);
        reset_L = 1'b0;
        drive(1, 0, 0);
        reset_L = 1'b1;
        check("mid_rst_cnt", 32'(bus.ret_count), 0);
        check("mid_rst_vret", 32'(bus.valid_ret), 0);
        check("mid_rst_dc", 32'(bus.drop_count), 0);
        check("mid_rst_dp", 32'(bus.drop_pulse), 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0);
            check($sformatf("mid_idle%0d_vout", i), 32'(bus.valid_out), 0);
            check($sformatf("mid_idle%0d_cnt", i), 32'(bus.ret_count), 0);
        end

        // 300 drops: the counter must stop at 255 rather than wrap.
        for (int i = 0; i < 304; i++) begin
            drive(0, 1, 32'(i));
            if (i == 106) check("sat_mid_dc", 32'(bus.drop_count), 100);
        end
        repeat (3) drive(0, 0, 0);
        check("sat_dc", 32'(bus.drop_count), 255);
        check("sat_dp_last", 32'(bus.drop_pulse), 1);
        check("sat_cnt", 32'(bus.ret_count), 4);
        check("sat_full", 32'(bus.ret_full), 1);
        check("sat_dret", bus.data_ret, 32'h0);
        drive(0, 0, 0);
        check("sat_dp_clear", 32'(bus.drop_pulse), 0);
        check("sat_dc_hold", 32'(bus.drop_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flops_recirc_param.md
FLOPS_RECIRC_PARAM -- requirements
Module: flops_recirc_param

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, minimum 1.
REQ-002 Parameter STAGES, default 2: pipeline register stages, minimum 1.
REQ-003 Parameter RET_DEPTH, default 4: return-buffer entries, power of two, minimum 2.
REQ-004 clk_2f  input  1: single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1: reset, synchronous and active-low.
REQ-006 active  input  1: 1 routes pipeline tail to the output and enables replay; 0 diverts the tail to the return buffer.
REQ-007 valid_in  input  1: data_in is valid this cycle.
REQ-008 data_in  input  WIDTH: input data word.
REQ-009 valid_out  output  1: data_out is valid this cycle.
REQ-010 data_out  output  WIDTH: delivered data word, all zeros when valid_out=0.
REQ-011 valid_ret  output  1: return buffer not empty.
REQ-012 data_ret  output  WIDTH: return-buffer head word, all zeros when empty.
REQ-013 ret_count  output  $clog2(RET_DEPTH+1): return-buffer occupancy.
REQ-014 ret_full  output  1: ret_count == RET_DEPTH.
REQ-015 drop_pulse  output  1: one-cycle pulse, a diverted word was discarded because the buffer was full.
REQ-016 drop_count  output  8: saturating count of discarded words.

Function
REQ-017 Pipeline: stage registers s[0..STAGES-1], each holding valid and WIDTH data; s[i] <= s[i-1] every cycle with no stall.
REQ-018 Head select, priority order:
  - valid_in=1: s[0] <= {1, data_in}.
  - else active=1 and buffer not empty: s[0] <= {1, head}; pop.
  - else s[0].valid <= 0, with data don't-care internally.
REQ-019 Tail routing is combinational on s[STAGES-1] and active:
  - valid_out = s[STAGES-1].valid & active.
  - data_out = s[STAGES-1].data when valid_out, else 0.
REQ-020 Latency: a word with valid_in=1 sampled at edge k appears on valid_out during the cycle after edge k+STAGES-1 (STAGES cycles).
REQ-021 Diversion: s[STAGES-1].valid=1 with active=0 pushes the tail word into the return buffer at the next edge.
REQ-022 Push (active=0) and pop (active=1) are mutually exclusive by construction; ret_count changes by at most 1 per cycle.
REQ-023 Full: a push attempted while ret_full=1 discards the word, leaves the buffer unchanged, asserts drop_pulse for exactly that cycle, and increments drop_count, saturating at 255.
REQ-024 Empty: with active=1, valid_in=0 and ret_count=0, s[0] loads invalid; no pop, no underflow.
REQ-025 Ordering: the buffer is FIFO; replayed words re-enter the pipeline in diversion order.
REQ-026 Pointers wrap modulo RET_DEPTH.
REQ-027 A word replayed while active=1 leaves STAGES cycles later on data_out if active is still 1; if active is 0 by then, it is diverted again.

Reset
REQ-028 While reset_L=0 at a rising edge:
  - all stage valids, buffer pointers, ret_count, drop_count and drop_pulse clear to 0.
  - the outputs are therefore valid_out=0, data_out=0, valid_ret=0, data_ret=0, ret_full=0.
REQ-029 Reset mid-operation discards all in-flight and buffered words with no drop_pulse; operation resumes on the first edge with reset_L=1.

Structure
REQ-030 A shared package holds the default constants DEF_WIDTH=32, DEF_STAGES=2 and DEF_RET_DEPTH=4, plus the drop-counter width of 8.
REQ-031 The return buffer is one sub-module, recirc_fifo (WIDTH, RET_DEPTH), with push, pop, head, count, full and empty; the top level holds the pipeline, the head mux and the drop logic.

Verification (WIDTH=32, STAGES=2, RET_DEPTH=4)
REQ-032 Reset, then active=1 and data_in=0xA5A5_0001 for one cycle -> valid_out=1, data_out=0xA5A5_0001 exactly 2 cycles later, for one cycle; ret_count stays 0.
REQ-033 active=0 and five consecutive words 0x10..0x14 -> ret_count reaches 4, ret_full=1, 0x14 is dropped, drop_pulse is seen once, drop_count=1.
REQ-034 Then active=1 with valid_in=0 -> data_out yields 0x10,0x11,0x12,0x13 on consecutive cycles, starting 2 cycles after the first pop; ret_count returns to 0.
REQ-035 Buffer holding 0x20, active=1, valid_in=1 with 0x30 -> 0x30 is output first; 0x20 is replayed only on the first cycle with valid_in=0.
REQ-036 Buffer holding 3 words, reset_L=0 for one edge -> ret_count=0, valid_ret=0, drop_count=0, and nothing is replayed afterwards.
REQ-037 Force 300 drops -> drop_count saturates at 255 and does not wrap.
